// File: rtl/pong_defs.sv
// Mode encodings for the pong count block, shared with the game logic so both
// sides always agree on the numbers used for each bound behaviour.
package pong_defs;

    localparam int MODE_WRAP   = 0;
    localparam int MODE_SAT    = 1;
    localparam int MODE_BOUNCE = 2;

endpackage

// File: rtl/counter_step.sv
// One-step next-state arithmetic for pong_counter: the next count, the next
// direction, and whether this step wrapped, clamped or reversed.
module counter_step
    import pong_defs::*;
#(
    parameter int WIDTH = 8,
    parameter int MIN   = 0,
    parameter int MAX   = 255,
    parameter int STEP  = 1,
    parameter int MODE  = MODE_WRAP
) (
    input  logic [WIDTH-1:0] c,
    input  logic             up,
    output logic [WIDTH-1:0] c_nxt,
    output logic             dir_nxt,
    output logic             hit
);

    // One extra bit so c+STEP can never overflow without being seen.
    localparam logic [WIDTH:0]   MAX_W  = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   LO_W   = (WIDTH+1)'(MIN + STEP);
    localparam logic [WIDTH-1:0] MIN_N  = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_N  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);

    logic [WIDTH:0]   c_w;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;

    assign c_w  = {1'b0, c};
    assign sum  = c_w + STEP_W;
    // Only used when c >= MIN+STEP, so the subtraction cannot underflow.
    assign diff = c - STEP_N;

    always_comb begin
        c_nxt   = c;
        dir_nxt = up;
        hit     = 1'b0;
        if (MODE == MODE_BOUNCE) begin
            if (up) begin
                if (sum >= MAX_W) begin
                    c_nxt   = MAX_N;
                    dir_nxt = 1'b0;
                    hit     = 1'b1;
                end else begin
                    c_nxt   = sum[WIDTH-1:0];
                end
            end else begin
                if (c_w <= LO_W) begin
                    c_nxt   = MIN_N;
                    dir_nxt = 1'b1;
                    hit     = 1'b1;
                end else begin
                    c_nxt   = diff;
                end
            end
        end else begin
            if (up) begin
                if (sum > MAX_W) begin
                    c_nxt = (MODE == MODE_SAT) ? MAX_N : MIN_N;
                    hit   = 1'b1;
                end else begin
                    c_nxt = sum[WIDTH-1:0];
                end
            end else begin
                if (c_w < LO_W) begin
                    c_nxt = (MODE == MODE_SAT) ? MIN_N : MAX_N;
                    hit   = 1'b1;
                end else begin
                    c_nxt = diff;
                end
            end
        end
    end

endmodule

// File: rtl/pong_counter.sv
// Bounded up/down counter with wrap, saturate or bounce behaviour at the bounds,
// a clamped parallel load and a registered terminal-count pulse.
module pong_counter
    import pong_defs::*;
#(
    parameter int WIDTH = 8,
    parameter int MIN   = 0,
    parameter int MAX   = 255,
    parameter int STEP  = 1,
    parameter int MODE  = MODE_WRAP
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             Up,
    input  logic             Ld,
    input  logic [WIDTH-1:0] LdVal,
    output logic [WIDTH-1:0] C,
    output logic             DirOut,
    output logic             Tc,
    output logic             AtMin,
    output logic             AtMax
);

    if (MIN >= MAX) begin : g_bad_bounds
        $error("pong_counter: MIN must be below MAX");
    end
    if (STEP == 0) begin : g_bad_step_zero
        $error("pong_counter: STEP must be non-zero");
    end
    if (STEP > MAX - MIN) begin : g_bad_step_span
        $error("pong_counter: STEP exceeds MAX-MIN");
    end
    if ((MAX >> WIDTH) != 0) begin : g_bad_width
        $error("pong_counter: MAX does not fit in WIDTH bits");
    end
    if (MODE != MODE_WRAP && MODE != MODE_SAT && MODE != MODE_BOUNCE) begin : g_bad_mode
        $error("pong_counter: unknown MODE");
    end

    localparam logic [WIDTH-1:0] MIN_N = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_N = WIDTH'(MAX);

    logic [WIDTH-1:0] c_q;
    logic             dir_q;
    logic             tc_q;
    logic [WIDTH-1:0] c_nxt;
    logic             dir_nxt;
    logic             hit;
    logic             step_up;
    logic [WIDTH-1:0] ld_clamped;

    // Bounce follows its own stored direction; the other modes obey Up live.
    assign step_up = (MODE == MODE_BOUNCE) ? dir_q : Up;

    counter_step #(
        .WIDTH (WIDTH),
        .MIN   (MIN),
        .MAX   (MAX),
        .STEP  (STEP),
        .MODE  (MODE)
    ) u_step (
        .c       (c_q),
        .up      (step_up),
        .c_nxt   (c_nxt),
        .dir_nxt (dir_nxt),
        .hit     (hit)
    );

    always_comb begin
        ld_clamped = LdVal;
        if (LdVal < MIN_N) begin
            ld_clamped = MIN_N;
        end else if (LdVal > MAX_N) begin
            ld_clamped = MAX_N;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            c_q   <= MIN_N;
            dir_q <= 1'b1;
            tc_q  <= 1'b0;
        end else if (Ld) begin
            c_q   <= ld_clamped;
            dir_q <= Up;
            tc_q  <= 1'b0;
        end else if (En) begin
            c_q   <= c_nxt;
            dir_q <= dir_nxt;
            tc_q  <= hit;
        end else begin
            tc_q  <= 1'b0;
        end
    end

    assign C      = c_q;
    assign DirOut = dir_q;
    assign Tc     = tc_q;
    assign AtMin  = (c_q == MIN_N);
    assign AtMax  = (c_q == MAX_N);

endmodule

// File: tb/tb_pong_counter.sv
// Self-checking bench for pong_counter: four instances (wrap, saturate, bounce,
// load clamp) share one stimulus bus; each vector checks the selected instance.
module tb_pong_counter;
    import pong_defs::*;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       Rst = 1'b1;
    logic       En = 1'b0;
    logic       Up = 1'b1;
    logic       Ld = 1'b0;
    logic [7:0] LdVal = 8'd0;

    logic [7:0] c_o [4];
    logic       dir_o [4];
    logic       tc_o [4];
    logic       amin_o [4];
    logic       amax_o [4];

    localparam int MINV [4] = '{0, 2, 0, 0};
    localparam int MAXV [4] = '{9, 10, 5, 150};

    pong_counter #(.WIDTH(8), .MIN(0), .MAX(9), .STEP(1), .MODE(MODE_WRAP)) u_wrap (
        .Clk(Clk), .Rst(Rst), .En(En), .Up(Up), .Ld(Ld), .LdVal(LdVal),
        .C(c_o[0]), .DirOut(dir_o[0]), .Tc(tc_o[0]), .AtMin(amin_o[0]), .AtMax(amax_o[0]));
    pong_counter #(.WIDTH(8), .MIN(2), .MAX(10), .STEP(3), .MODE(MODE_SAT)) u_sat (
        .Clk(Clk), .Rst(Rst), .En(En), .Up(Up), .Ld(Ld), .LdVal(LdVal),
        .C(c_o[1]), .DirOut(dir_o[1]), .Tc(tc_o[1]), .AtMin(amin_o[1]), .AtMax(amax_o[1]));
    pong_counter #(.WIDTH(8), .MIN(0), .MAX(5), .STEP(2), .MODE(MODE_BOUNCE)) u_bounce (
        .Clk(Clk), .Rst(Rst), .En(En), .Up(Up), .Ld(Ld), .LdVal(LdVal),
        .C(c_o[2]), .DirOut(dir_o[2]), .Tc(tc_o[2]), .AtMin(amin_o[2]), .AtMax(amax_o[2]));
    pong_counter #(.WIDTH(8), .MIN(0), .MAX(150), .STEP(1), .MODE(MODE_SAT)) u_clamp (
        .Clk(Clk), .Rst(Rst), .En(En), .Up(Up), .Ld(Ld), .LdVal(LdVal),
        .C(c_o[3]), .DirOut(dir_o[3]), .Tc(tc_o[3]), .AtMin(amin_o[3]), .AtMax(amax_o[3]));

    typedef struct {
        int         sel;
        logic       rst, ld, en, up;
        logic [7:0] ldval;
        logic [7:0] c;
        logic       dir, tc;
    } vec_t;

    typedef struct {
        int         sel;
        int         idx;
        logic [7:0] c;
        logic       dir, tc, amin, amax;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_no = 0;

    function automatic vec_t mk(int sel, bit rst, bit ld, bit en, bit up, int ldval,
                                int c, bit dir, bit tc);
        vec_t v;
        v.sel = sel; v.rst = rst; v.ld = ld; v.en = en; v.up = up;
        v.ldval = 8'(ldval); v.c = 8'(c); v.dir = dir; v.tc = tc;
        return v;
    endfunction

    task automatic chk(input string what, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL vec%0d %s: got %0d expected %0d", idx, what, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge Clk);
        Rst = v.rst; Ld = v.ld; En = v.en; Up = v.up; LdVal = v.ldval;
        e.sel  = v.sel;
        e.idx  = vec_no;
        e.c    = v.c;
        e.dir  = v.dir;
        e.tc   = v.tc;
        e.amin = (int'(v.c) == MINV[v.sel]);
        e.amax = (int'(v.c) == MAXV[v.sel]);
        sb.push_back(e);
        vec_no++;
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        chk("C",      e.idx, int'(c_o[e.sel]),  int'(e.c));
        chk("DirOut", e.idx, int'(dir_o[e.sel]), int'(e.dir));
        chk("Tc",     e.idx, int'(tc_o[e.sel]),  int'(e.tc));
        chk("AtMin",  e.idx, int'(amin_o[e.sel]), int'(e.amin));
        chk("AtMax",  e.idx, int'(amax_o[e.sel]), int'(e.amax));
    endtask

    initial begin
        // Reset state of every instance, then an idle cycle must hold it.
        vecs.push_back(mk(0, 1, 0, 0, 1, 0,   0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0,   2, 1, 0));
        vecs.push_back(mk(2, 1, 0, 0, 1, 0,   0, 1, 0));
        vecs.push_back(mk(3, 1, 0, 0, 1, 0,   0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   2, 1, 0));

        // Wrap 0..9 step 1, twelve up steps.
        for (int i = 1; i <= 12; i++)
            vecs.push_back(mk(0, 0, 0, 1, 1, 0, i % 10, 1, (i == 10)));
        // Down wrap from 2: 1, 0, then 9 with Tc.
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 9, 0, 1));

        // Saturate 2..10 step 3.
        vecs.push_back(mk(1, 0, 1, 0, 1, 8,   8, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 0,  10, 1, 1));
        vecs.push_back(mk(1, 0, 0, 1, 1, 0,  10, 1, 1));
        vecs.push_back(mk(1, 0, 0, 1, 1, 0,  10, 1, 1));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0,   7, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0,   4, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0,   2, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0,   2, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   2, 0, 0));

        // Bounce 0..5 step 2; Up held low while counting must be ignored.
        vecs.push_back(mk(2, 0, 1, 0, 1, 1,   1, 1, 0));
        vecs.push_back(mk(2, 0, 0, 1, 0, 0,   3, 1, 0));
        vecs.push_back(mk(2, 0, 0, 1, 0, 0,   5, 0, 1));
        vecs.push_back(mk(2, 0, 0, 1, 0, 0,   3, 0, 0));
        vecs.push_back(mk(2, 0, 0, 1, 0, 0,   1, 0, 0));
        vecs.push_back(mk(2, 0, 0, 1, 0, 0,   0, 1, 1));
        vecs.push_back(mk(2, 0, 0, 1, 0, 0,   2, 1, 0));

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i]);

        // Load clamp above MAX, then load with En in the same cycle.
        apply(mk(3, 0, 1, 0, 1, 200, 150, 1, 0));
        apply(mk(3, 0, 1, 1, 0, 20,   20, 0, 0));
        apply(mk(3, 0, 0, 1, 0, 0,    19, 0, 0));

        // Reset beats Ld and En at C=7; counting resumes right after release.
        apply(mk(0, 0, 1, 0, 1, 7,    7, 1, 0));
        apply(mk(0, 1, 1, 1, 0, 3,    0, 1, 0));
        apply(mk(0, 0, 0, 1, 1, 0,    1, 1, 0));
        apply(mk(0, 0, 0, 1, 1, 0,    2, 1, 0));

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_counter.md
PONG_COUNTER -- requirements
Module: pong_counter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning count register width in bits.
REQ-002 The module SHALL have parameter MIN, default 0, meaning lower count bound.
REQ-003 The module SHALL have parameter MAX, default 255, meaning upper count bound.
REQ-004 The module SHALL have parameter STEP, default 1, meaning increment/decrement per enabled cycle.
REQ-005 The module SHALL have parameter MODE, default 0, meaning bound behaviour: 0 wrap, 1 saturate, 2 bounce.
REQ-006 Port Clk  input  1  is the single clock; all state updates occur on its rising edge.
REQ-007 Port Rst  input  1  is the reset: synchronous, active-high.
REQ-008 Port En  input  1  enables one count step per cycle.
REQ-009 Port Up  input  1  sets direction: 1 up, 0 down; in MODE 2 it is sampled only on Ld.
REQ-010 Port Ld  input  1  loads LdVal.
REQ-011 Port LdVal  input  WIDTH  is the load value.
REQ-012 Port C  output  WIDTH  is the registered count.
REQ-013 Port DirOut  output  1  is the registered effective direction: 1 up, 0 down.
REQ-014 Port Tc  output  1  is the registered terminal-count pulse.
REQ-015 Port AtMin  output  1  is combinational (C == MIN).
REQ-016 Port AtMax  output  1  is combinational (C == MAX).

Function
REQ-017 Priority SHALL be Rst > Ld > En; with none asserted, C and DirOut hold and Tc = 0.
REQ-018 Ld SHALL set C to LdVal clamped into [MIN,MAX], set DirOut = Up, set Tc = 0, with a 1-cycle latency.
REQ-019 In MODE 0 and 1, DirOut SHALL follow Up on every En cycle.
REQ-020 Step arithmetic SHALL use WIDTH+1 bits so C+STEP and C-STEP never overflow undetected.
REQ-021 MODE 0: up step with C+STEP > MAX SHALL give C = MIN; down step with C < MIN+STEP SHALL give C = MAX; the overshoot is discarded.
REQ-022 MODE 1: an out-of-range step SHALL clamp C to MAX (up) or MIN (down); further steps at the bound hold C.
REQ-023 MODE 2: up step with C+STEP >= MAX SHALL give C = MAX and DirOut = 0; down step with C <= MIN+STEP SHALL give C = MIN and DirOut = 1.
REQ-024 Tc SHALL be 1 for exactly the cycle following any En step that wrapped, clamped, or reversed, including every held step in MODE 1.
REQ-025 A step that lands exactly on a bound without exceeding it SHALL NOT assert Tc in MODE 0/1; in MODE 2 it SHALL assert Tc, because a reversal occurs.
REQ-026 Ld with En in the same cycle SHALL perform the load only.
REQ-027 Elaboration SHALL fail when any of these holds: MIN >= MAX, STEP == 0, STEP > MAX-MIN, or MAX >= 2**WIDTH.

Reset
REQ-028 Rst at a rising edge SHALL set C = MIN, DirOut = 1, Tc = 0, overriding Ld and En.
REQ-029 Rst asserted mid-count or mid-reversal SHALL discard the pending step; counting resumes the cycle after Rst deasserts.

Structure
REQ-030 The MODE encodings (WRAP=0, SAT=1, BOUNCE=2) SHALL be defined as named constants in a shared header pong_defs, used by this block and the game logic.
REQ-031 The next-state arithmetic (next C, next direction, bound-hit flag) SHALL be one combinational sub-module, counter_step; pong_counter holds the registers and the load/priority logic.

Verification
REQ-032 Bench SHALL cover: MODE 0, WIDTH 8, MIN 0, MAX 9, STEP 1, Up = 1, En held 12 cycles -> C = 1..9, 0, 1, 2; Tc high only in the cycle C = 0.
REQ-033 Bench SHALL cover: MODE 1, MIN 2, MAX 10, STEP 3, Ld 8 then En up 3 cycles -> C = 10, 10, 10 with Tc = 1, 1, 1; then Up = 0 -> 7, 4, 2.
REQ-034 Bench SHALL cover: MODE 2, MIN 0, MAX 5, STEP 2, Ld 1 with Up = 1, En 6 cycles -> C = 3, 5, 3, 1, 0, 2; DirOut falls at C = 5 and rises at C = 0.
REQ-035 Bench SHALL cover: Ld 200 with MAX 150 -> C = 150; simultaneous Ld and En -> load only.
REQ-036 Bench SHALL cover: Rst asserted with Ld and En both high at C = 7 -> next C = MIN, DirOut = 1, Tc = 0; counting resumes one cycle after release.
